// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter: round-robin grant held for the whole cycle,
// with a per-transfer ack watchdog that aborts hung transfers with an error pulse.
module wb_arbiter_2m #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        wbs0_cyc_i,
    input  logic        wbs0_stb_i,
    input  logic        wbs0_we_i,
    input  logic [29:0] wbs0_addr_i,
    input  logic [2:0]  wbs0_cti_i,
    input  logic [1:0]  wbs0_bte_i,
    input  logic [3:0]  wbs0_sel_i,
    input  logic [31:0] wbs0_data_i,
    output logic [31:0] wbs0_data_o,
    output logic        wbs0_ack_o,
    output logic        wbs0_err_o,

    input  logic        wbs1_cyc_i,
    input  logic        wbs1_stb_i,
    input  logic        wbs1_we_i,
    input  logic [29:0] wbs1_addr_i,
    input  logic [2:0]  wbs1_cti_i,
    input  logic [1:0]  wbs1_bte_i,
    input  logic [3:0]  wbs1_sel_i,
    input  logic [31:0] wbs1_data_i,
    output logic [31:0] wbs1_data_o,
    output logic        wbs1_ack_o,
    output logic        wbs1_err_o,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [29:0] wbm_addr_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_data_o,
    input  logic [31:0] wbm_data_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,

    output logic        timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2
    } state_t;

    // Last count value before expiry; unused when the watchdog is disabled.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        (TIMEOUT == 0) ? '0 : CNT_WIDTH'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic                   last_q, last_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic gnt0, gnt1, gnt_stb, abort;

    assign gnt0    = (state_q == S_GNT0);
    assign gnt1    = (state_q == S_GNT1);
    assign gnt_stb = (gnt0 & wbs0_stb_i) | (gnt1 & wbs1_stb_i);
    assign abort   = (TIMEOUT != 0) & gnt_stb & (cnt_q == CNT_LAST) & ~wbm_ack_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            S_IDLE: begin
                if (wbs0_cyc_i && wbs1_cyc_i) begin
                    if (last_q) begin
                        state_d = S_GNT0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = S_GNT1;
                        last_d  = 1'b1;
                    end
                end else if (wbs0_cyc_i) begin
                    state_d = S_GNT0;
                    last_d  = 1'b0;
                end else if (wbs1_cyc_i) begin
                    state_d = S_GNT1;
                    last_d  = 1'b1;
                end
            end
            S_GNT0: if (!wbs0_cyc_i) state_d = S_IDLE;
            S_GNT1: if (!wbs1_cyc_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Counts only while a granted strobe waits; any termination restarts it.
    always_comb begin
        cnt_d = '0;
        if (gnt_stb && !wbm_ack_i && !wbm_err_i && !abort)
            cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    always_comb begin
        wbm_cyc_o   = 1'b0;
        wbm_stb_o   = 1'b0;
        wbm_we_o    = 1'b0;
        wbm_addr_o  = '0;
        wbm_cti_o   = '0;
        wbm_bte_o   = '0;
        wbm_sel_o   = '0;
        wbm_data_o  = '0;
        wbs0_ack_o  = 1'b0;
        wbs0_err_o  = 1'b0;
        wbs0_data_o = '0;
        wbs1_ack_o  = 1'b0;
        wbs1_err_o  = 1'b0;
        wbs1_data_o = '0;
        timeout     = abort;
        if (gnt0) begin
            wbm_cyc_o   = wbs0_cyc_i;
            wbm_stb_o   = wbs0_stb_i & ~abort;
            wbm_we_o    = wbs0_we_i;
            wbm_addr_o  = wbs0_addr_i;
            wbm_cti_o   = wbs0_cti_i;
            wbm_bte_o   = wbs0_bte_i;
            wbm_sel_o   = wbs0_sel_i;
            wbm_data_o  = wbs0_data_i;
            wbs0_ack_o  = wbm_ack_i & ~abort;
            wbs0_err_o  = wbm_err_i | abort;
            wbs0_data_o = wbm_data_i;
        end else if (gnt1) begin
            wbm_cyc_o   = wbs1_cyc_i;
            wbm_stb_o   = wbs1_stb_i & ~abort;
            wbm_we_o    = wbs1_we_i;
            wbm_addr_o  = wbs1_addr_i;
            wbm_cti_o   = wbs1_cti_i;
            wbm_bte_o   = wbs1_bte_i;
            wbm_sel_o   = wbs1_sel_i;
            wbm_data_o  = wbs1_data_i;
            wbs1_ack_o  = wbm_ack_i & ~abort;
            wbs1_err_o  = wbm_err_i | abort;
            wbs1_data_o = wbm_data_i;
        end
    end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone (classic/registered-feedback) arbiter between the CPU-side connectors and the system bus.
- Master 0 is the instruction-fetch connector; master 1 is the data connector.
- Round-robin grant, held for the whole cycle (cyc high), so locked/back-to-back accesses from one master are not split.
- Includes a per-transfer ack watchdog that terminates hung transfers with an error pulse, so a dead slave cannot stall the CPU forever.

Parameters:
TIMEOUT, 255, cycles with stb high and no ack before the transfer is aborted; 0 disables the watchdog.
CNT_WIDTH, 8, width of watchdog counter; must satisfy 2^CNT_WIDTH > TIMEOUT.

Ports:
clk  in  1  bus clock, rising edge.
rst  in  1  asynchronous reset, active-high.
wbs0_cyc_i, wbs0_stb_i, wbs0_we_i  in  1 each  master 0 cycle / strobe / write.
wbs0_addr_i  in  30  master 0 word address [31:2].
wbs0_cti_i  in  3  master 0 cycle type.
wbs0_bte_i  in  2  master 0 burst type.
wbs0_sel_i  in  4  master 0 byte select.
wbs0_data_i  in  32  master 0 write data.
wbs0_data_o  out  32  read data to master 0.
wbs0_ack_o, wbs0_err_o  out  1 each  ack / error to master 0.
wbs1_*  same set and widths as wbs0_*, for master 1.
wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  to slave bus.
wbm_addr_o  out  30; wbm_cti_o  out  3; wbm_bte_o  out  2; wbm_sel_o  out  4; wbm_data_o  out  32.
wbm_data_i  in  32  slave read data.
wbm_ack_i, wbm_err_i  in  1 each  slave ack / error.
timeout  out  1  one-cycle pulse when the watchdog fires (for the exception unit).

Behaviour:
- Registered state grant: S_IDLE, S_GNT0, S_GNT1. Register last: last master granted.
- Reset (async): state = S_IDLE, last = 1 (master 0 wins the first tie), counter = 0.
  - All wbm_* outputs, wbsN_ack_o, wbsN_err_o, wbsN_data_o and timeout are 0 while rst is high and in S_IDLE.
- S_IDLE transitions:
  - Only cyc0 high -> S_GNT0.
  - Only cyc1 high -> S_GNT1.
  - Both high -> grant the master != last.
  - Neither -> stay in S_IDLE.
  - last updates on entry to a grant state.
  - Grant latency: one cycle from cyc rise to wbm_cyc_o rise.
- S_GNTn: wbm_* outputs are combinationally muxed from master n.
  - wbm_stb_o is additionally forced 0 in the watchdog-abort cycle.
  - Leave S_GNTn -> S_IDLE when wbsn_cyc_i = 0. At least one idle cycle separates grants (bus turnaround).
  - The other master's request waits. Its ack/err/data outputs stay 0.
- Return path: wbsn_ack_o = grant n & wbm_ack_i & ~abort.
  - wbsn_err_o = grant n & (wbm_err_i | abort).
  - wbsn_data_o = grant n ? wbm_data_i : 0.
- Watchdog:
  - Counter clears when not granted, when stb = 0, and on ack or err.
  - Otherwise it increments each cycle while granted and stb is high.
  - abort = (TIMEOUT != 0) & (count == TIMEOUT - 1) & ~wbm_ack_i.
  - In the abort cycle: err pulses to the granted master, timeout pulses, and the counter clears.
  - The master is expected to drop cyc; the grant is still held until cyc falls.
- Simultaneous ack and timeout expiry: ack wins, no error.
- Master drops cyc mid-wait (suspend): return to S_IDLE next cycle; a late slave ack is not forwarded to anyone.
- Reset mid-transfer: immediate return to the reset values above; the slave sees cyc drop asynchronously.

Test Plan:
- Master 0 single read, addr 0x0000_1000>>2, slave acks after 2 wait states -> wbm_cyc_o high from cycle 1; wbs0_ack_o one cycle carrying 0xDEADBEEF; wbs1_ack_o stays 0.
- cyc0 and cyc1 rise in the same cycle after reset -> master 0 granted first. Master 0 releases, one idle cycle, then master 1 granted. A repeated simultaneous request is granted to master 0 again (round-robin).
- Master 1 holds cyc through three strobes (sel 4'b0011, 4'b1100, 4'b1111) while cyc0 stays high -> all three go to the slave without switching; master 0 is granted only after cyc1 falls.
- TIMEOUT=4, slave never acks -> exactly one cycle of wbs0_err_o and timeout, 4 cycles after stb; wbm_stb_o low in that cycle; the counter restarts if stb is held.
- Ack arrives in the same cycle as watchdog expiry -> wbs_ack_o = 1, wbs_err_o = 0, timeout = 0.
- rst asserted mid-wait with master 1 granted -> wbm_cyc_o drops without a clock edge; after release, a simultaneous request grants master 0.
